// File: rtl/video_link_sequencer.sv
// Bring-up, supervision and tear-free update scheduling for the HDMI pixel datapath.
// Build option: define LOCK_RECOVER_EN to re-run bring-up on lock loss instead of latching a fault.
`timescale 1ns/1ps
module video_link_sequencer #(
  parameter int SETTLE_CYCLES    = 1024,
  parameter int WARMUP_FRAMES    = 2,
  parameter int UPD_WIN_CYCLES   = 1600,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int FRAME_W          = 16
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  input  logic               locked,
  input  logic               v_sync,
  input  logic               upd_req,
  output logic               enc_rst,
  output logic               pix_en,
  output logic               link_up,
  output logic               upd_ack,
  output logic               upd_win,
  output logic               fault,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int SC_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int WF_W = (WARMUP_FRAMES  > 1) ? $clog2(WARMUP_FRAMES)  : 1;
  localparam int UW_W = (UPD_WIN_CYCLES > 1) ? $clog2(UPD_WIN_CYCLES) : 1;

  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [WF_W-1:0] WARM_LAST   = WF_W'(WARMUP_FRAMES - 1);
  localparam logic [UW_W-1:0] WIN_LAST    = UW_W'(UPD_WIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_SETTLE,
    S_WARMUP,
    S_ACTIVE,
    S_FAULT
  } state_e;

`ifdef LOCK_RECOVER_EN
  localparam state_e LOSS_STATE = S_WAIT_LOCK;
`else
  localparam state_e LOSS_STATE = S_FAULT;
`endif

  state_e              state_q, state_d;
  logic                lk_meta_q, lk_meta_d;
  logic                lk_s_q, lk_s_d;
  logic                vs_q, vs_d;
  logic [SC_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [WF_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [UW_W-1:0]     win_cnt_q, win_cnt_d;
  logic                enc_rst_q, enc_rst_d;
  logic                pix_en_q, pix_en_d;
  logic                link_up_q, link_up_d;
  logic                upd_ack_q, upd_ack_d;
  logic                upd_win_q, upd_win_d;
  logic                fault_q, fault_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic vs_asserted;
  logic fe;
  logic grant;
  logic kill_win;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q      <= S_WAIT_LOCK;
      lk_meta_q    <= 1'b0;
      lk_s_q       <= 1'b0;
      vs_q         <= 1'b0;
      settle_cnt_q <= '0;
      warm_cnt_q   <= '0;
      win_cnt_q    <= '0;
      enc_rst_q    <= 1'b1;
      pix_en_q     <= 1'b0;
      link_up_q    <= 1'b0;
      upd_ack_q    <= 1'b0;
      upd_win_q    <= 1'b0;
      fault_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      lk_meta_q    <= lk_meta_d;
      lk_s_q       <= lk_s_d;
      vs_q         <= vs_d;
      settle_cnt_q <= settle_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      win_cnt_q    <= win_cnt_d;
      enc_rst_q    <= enc_rst_d;
      pix_en_q     <= pix_en_d;
      link_up_q    <= link_up_d;
      upd_ack_q    <= upd_ack_d;
      upd_win_q    <= upd_win_d;
      fault_q      <= fault_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Sequencer: bring-up counters and lock supervision.
  always_comb begin
    lk_meta_d    = locked;
    lk_s_d       = lk_meta_q;
    vs_asserted  = VSYNC_ACTIVE_LOW ? ~v_sync : v_sync;
    vs_d         = vs_asserted;
    fe           = vs_asserted & ~vs_q;
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    warm_cnt_d   = warm_cnt_q;

    case (state_q)
      S_WAIT_LOCK: begin
        if (lk_s_q) begin
          state_d      = S_SETTLE;
          settle_cnt_d = SETTLE_LAST;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d    = S_WARMUP;
          warm_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      S_WARMUP: begin
        if (fe) begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d = S_ACTIVE;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        state_d = S_ACTIVE;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (!lk_s_q && (state_q == S_SETTLE || state_q == S_WARMUP || state_q == S_ACTIVE)) begin
      state_d = LOSS_STATE;
    end
  end

  // Registered outputs are derived from the next state so they change with it.
  always_comb begin
    enc_rst_d = !(state_d == S_WARMUP || state_d == S_ACTIVE);
    pix_en_d  = (state_d == S_ACTIVE);
    link_up_d = (state_d == S_ACTIVE);

    frame_cnt_d = '0;
    if (state_d == S_ACTIVE) begin
      frame_cnt_d = (state_q == S_ACTIVE && fe) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

`ifdef LOCK_RECOVER_EN
    fault_d = 1'b0;
`else
    fault_d = fault_q | (state_d == S_FAULT);
`endif
  end

  // Update scheduler: outside ACTIVE grant at once, inside ACTIVE only at a frame edge.
  always_comb begin
    grant = 1'b0;
    if (state_q == S_ACTIVE) begin
      grant = fe & upd_req;
    end else if (state_q != S_FAULT) begin
      grant = upd_req & ~upd_win_q;
    end

    kill_win = (state_d == S_ACTIVE && state_q != S_ACTIVE) ||
               (state_d == S_WAIT_LOCK && state_q != S_WAIT_LOCK) ||
               (state_d == S_FAULT);

    upd_ack_d = 1'b0;
    upd_win_d = upd_win_q;
    win_cnt_d = win_cnt_q;
    if (kill_win) begin
      upd_win_d = 1'b0;
      win_cnt_d = '0;
    end else if (grant) begin
      upd_ack_d = 1'b1;
      upd_win_d = 1'b1;
      win_cnt_d = WIN_LAST;
    end else if (upd_win_q) begin
      if (win_cnt_q == '0) begin
        upd_win_d = 1'b0;
      end else begin
        win_cnt_d = win_cnt_q - 1'b1;
      end
    end
  end

  assign enc_rst   = enc_rst_q;
  assign pix_en    = pix_en_q;
  assign link_up   = link_up_q;
  assign upd_ack   = upd_ack_q;
  assign upd_win   = upd_win_q;
  assign fault     = fault_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/video_link_sequencer.md
# video_link_sequencer

Pixel-domain controller that brings up, supervises and gates the HDMI video datapath (vga_generator → three tmds_encoder_dvi → serializers). It holds the encoders in reset until the clock wizard reports lock and a settle interval elapses, then sends black frames for a warm-up period before enabling pixels. It also schedules tear-free content updates from the vending logic by granting a write window only at the start of vertical sync.

## Interface
Parameters:
- SETTLE_CYCLES, 1024: clk_25mhz cycles encoders stay in reset after lock is seen (≥1)
- WARMUP_FRAMES, 2: black frames sent after encoder reset release (≥1)
- UPD_WIN_CYCLES, 1600: length of the granted update window in cycles (≥1)
- VSYNC_ACTIVE_LOW, 1: 1 = v_sync asserted low (640x480), 0 = asserted high
- FRAME_W, 16: frame counter width

Ports:
- clk_25mhz  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high
- locked  in  1  clock-wizard lock, asynchronous; 2-flop synchronized internally
- v_sync  in  1  from vga_generator, polarity per VSYNC_ACTIVE_LOW
- upd_req  in  1  level request from vending logic for an update window
- enc_rst  out  1  reset to all three TMDS encoders
- pix_en  out  1  1 = pass RGB, 0 = downstream forces RGB to 0
- link_up  out  1  high only in ACTIVE
- upd_ack  out  1  one-cycle pulse at window grant
- upd_win  out  1  high for the granted window
- fault  out  1  sticky lock-loss flag (see Configuration)
- frame_cnt  out  FRAME_W  frames since entering ACTIVE

## Operation
- All outputs registered. Reset values: enc_rst=1, pix_en=0, link_up=0, upd_ack=0, upd_win=0, fault=0, frame_cnt=0; state=WAIT_LOCK.
- lk_s = locked after two flops. Frame edge fe = v_sync at asserted level this cycle AND vs_q (previous sample) deasserted.
- WAIT_LOCK: enc_rst=1, pix_en=0. lk_s=1 → SETTLE, counter = SETTLE_CYCLES−1.
- SETTLE: enc_rst=1. Counter decrements; at 0 → WARMUP, frame counter for warm-up = 0.
- WARMUP: enc_rst=0, pix_en=0. Each fe increments warm-up count; on WARMUP_FRAMES-th fe → ACTIVE.
- ACTIVE: enc_rst=0, pix_en=1, link_up=1. frame_cnt increments on each fe, wraps modulo 2^FRAME_W; cleared whenever not in ACTIVE.
- lk_s=0 in SETTLE/WARMUP/ACTIVE: next state per Configuration; has priority over every other transition.
- Update scheduler:
  - State ≠ ACTIVE and upd_req=1 and upd_win=0: grant next cycle (nothing visible).
  - ACTIVE: grant only on fe with upd_req=1; requests arriving mid-frame wait for next fe.
  - Grant: upd_ack=1 for one cycle, upd_win=1 for exactly UPD_WIN_CYCLES cycles starting same cycle.
  - Requester drops upd_req after upd_ack; upd_req still high at a later grant point is a new request.
  - Transition into ACTIVE or WAIT_LOCK terminates any open window (upd_win=0 next cycle).

## Timing
- locked rise at edge N → SETTLE at edge N+3; enc_rst falls SETTLE_CYCLES cycles later.
- fe in ACTIVE at edge K → upd_ack/upd_win high from edge K+1; frame_cnt updated at K+1.
- link_up/pix_en rise at edge after the final warm-up fe.
- Lock loss seen by lk_s at edge M → enc_rst=1, pix_en=0, link_up=0 at M+1.
- Async reset mid-window or mid-count: all outputs immediately to reset values.

## Configuration
- LOCK_RECOVER_EN defined: lock loss → WAIT_LOCK, full re-bring-up automatic; fault stays 0.
- Undefined: lock loss → FAULT state (enc_rst=1, pix_en=0, link_up=0, upd_win=0, no grants), fault=1; exit only via reset.

## Test plan
- SETTLE_CYCLES=8, WARMUP_FRAMES=2: locked rises at cycle 10 → enc_rst falls at cycle 21, link_up rises after 2nd v_sync edge.
- ACTIVE, upd_req raised mid-frame → no ack until next v_sync edge; then upd_ack 1 cycle, upd_win exactly UPD_WIN_CYCLES=16 cycles.
- ACTIVE, upd_req held high across 3 frames → 3 grants, frame_cnt +3; FRAME_W=2 from 3 → wraps to 0.
- upd_req in WARMUP → ack next cycle; window closes at entry to ACTIVE.
- Drop locked in ACTIVE mid-window: with LOCK_RECOVER_EN → WAIT_LOCK, upd_win=0, re-bring-up on relock; without → fault=1 sticky until reset.
- Assert reset during SETTLE → all outputs at reset values immediately; bring-up restarts after release.
